// File: rtl/dm_cache_ctrl_if.sv
// CPU request port and memory initiator port of the direct-mapped cache.
// slave = cache controller side, master = CPU/memory side.
interface dm_cache_ctrl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic        cpu_done;
  logic [31:0] cpu_rdata;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ready, cpu_done, cpu_rdata,
    output mem_ren, mem_wen, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ready, cpu_done, cpu_rdata,
    input  mem_ren, mem_wen, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache, one-word lines.
// Define CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module dm_cache_ctrl #(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_BITS  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef CACHE_STATS_EN
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
`endif
  dm_cache_ctrl_if.slave bus
);

  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int PAD      = 32 - ADDR_BITS;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] COMPARE   = 3'd1;
  localparam logic [2:0] WRITEBACK = 3'd2;
  localparam logic [2:0] ALLOCATE  = 3'd3;
  localparam logic [2:0] WAIT      = 3'd4;

  logic [2:0]           state;
  logic                 req_we;
  logic [ADDR_BITS-1:0] req_addr;
  logic [31:0]          req_wdata;

  logic [LINES-1:0]     valid;
  logic [LINES-1:0]     dirty;
  logic [TAG_BITS-1:0]  tag_q  [LINES];
  logic [31:0]          data_q [LINES];

  logic                 done;
  logic [31:0]          rdata;
  logic                 ren;
  logic                 wen;
  logic [31:0]          maddr;
  logic [31:0]          wdata;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   rtag;
  logic                  hit;
  logic                  victim_dirty;
  logic                  accept;
  logic                  unused_hi;

  assign idx  = req_addr[INDEX_BITS-1:0];
  assign rtag = req_addr[ADDR_BITS-1:INDEX_BITS];
  assign hit  = valid[idx] && (tag_q[idx] == rtag);
  assign victim_dirty = valid[idx] && dirty[idx];
  assign accept = bus.cpu_req && (state == IDLE);
  assign unused_hi = ^bus.cpu_addr[31:ADDR_BITS];

  assign bus.cpu_ready = (state == IDLE);
  assign bus.cpu_done  = done;
  assign bus.cpu_rdata = rdata;
  assign bus.mem_ren   = ren;
  assign bus.mem_wen   = wen;
  assign bus.mem_addr  = maddr;
  assign bus.mem_wdata = wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      valid     <= '0;
      dirty     <= '0;
      done      <= 1'b0;
      rdata     <= '0;
      ren       <= 1'b0;
      wen       <= 1'b0;
      maddr     <= '0;
      wdata     <= '0;
    end else begin
      done <= 1'b0;
      ren  <= 1'b0;
      wen  <= 1'b0;
      unique case (1'b1)
        (state == IDLE): begin
          if (accept) begin
            req_we    <= bus.cpu_we;
            req_addr  <= bus.cpu_addr[ADDR_BITS-1:0];
            req_wdata <= bus.cpu_wdata;
            state     <= COMPARE;
          end
        end
        (state == COMPARE): begin
          if (hit) begin
            if (req_we) dirty[idx] <= 1'b1;
            else        rdata      <= data_q[idx];
            done  <= 1'b1;
            state <= IDLE;
          end else if (victim_dirty) begin
            wen   <= 1'b1;
            maddr <= {{PAD{1'b0}}, tag_q[idx], idx};
            wdata <= data_q[idx];
            state <= WRITEBACK;
          end else begin
            ren   <= 1'b1;
            maddr <= {{PAD{1'b0}}, req_addr};
            state <= ALLOCATE;
          end
        end
        (state == WRITEBACK): begin
          ren   <= 1'b1;
          maddr <= {{PAD{1'b0}}, req_addr};
          state <= ALLOCATE;
        end
        (state == ALLOCATE): begin
          state <= WAIT;
        end
        (state == WAIT): begin
          valid[idx] <= 1'b1;
          dirty[idx] <= 1'b0;
          state      <= COMPARE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage needs no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (state == WAIT) begin
      data_q[idx] <= bus.mem_rdata;
      tag_q[idx]  <= rtag;
    end else if (state == COMPARE && hit && req_we) begin
      data_q[idx] <= req_wdata;
    end
  end

`ifdef CACHE_STATS_EN
  logic refill;

  // Only the first COMPARE of a request classifies it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refill     <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state == WAIT) begin
        refill <= 1'b1;
      end else if (state == COMPARE) begin
        if (!refill) begin
          if (hit) begin
            if (hit_count != '1) hit_count <= hit_count + 32'd1;
          end else begin
            if (miss_count != '1) miss_count <= miss_count + 32'd1;
          end
        end
        if (hit) refill <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl with a 1-cycle registered memory model.
// Memory default content: mem[a] = 32'hDEAD_0000 | a.
module tb_dm_cache_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  dm_cache_ctrl_if bus ();

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  dm_cache_ctrl #(
    .INDEX_BITS(6),
    .ADDR_BITS(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef CACHE_STATS_EN
    .hit_count (hit_count),
    .miss_count(miss_count),
`endif
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] wmem [int];
  logic [31:0] mem_q;

  assign bus.mem_rdata = mem_q;

  function automatic logic [31:0] mem_peek(input logic [31:0] a);
    int k;
    k = int'(a[15:0]);
    if (wmem.exists(k)) return wmem[k];
    return 32'hDEAD_0000 | {16'h0, a[15:0]};
  endfunction

  // wen wins over ren, read data registered one cycle later
  always @(posedge clk) begin
    if (bus.mem_wen) wmem[int'(bus.mem_addr[15:0])] = bus.mem_wdata;
    else if (bus.mem_ren) mem_q <= mem_peek(bus.mem_addr);
  end

  task automatic do_req(
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd_in,
    output int          lat,
    output logic [31:0] rd,
    output int          rn,
    output logic [31:0] ra,
    output int          wn,
    output logic [31:0] wa,
    output logic [31:0] wd,
    output int          both
  );
    rn = 0; wn = 0; both = 0;
    ra = '0; wa = '0; wd = '0;
    lat = 99; rd = '0;
    @(negedge clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd_in;
    @(posedge clk);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.mem_ren && bus.mem_wen) both++;
      if (bus.mem_ren) begin rn++; ra = bus.mem_addr; end
      if (bus.mem_wen) begin
        wn++; wa = bus.mem_addr; wd = bus.mem_wdata;
      end
      if (bus.cpu_done) begin
        lat = c;
        rd  = bus.cpu_rdata;
        break;
      end
    end
  endtask

  int          lat, rn, wn, both;
  logic [31:0] rd, ra, wa, wd;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.cpu_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", bus.cpu_ready);
    end
    checks++;
    if ({bus.cpu_done, bus.mem_ren, bus.mem_wen} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 000",
               {bus.cpu_done, bus.mem_ren, bus.mem_wen});
    end
    checks++;
    if ({bus.cpu_rdata, bus.mem_addr, bus.mem_wdata} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h want 0",
               bus.cpu_rdata, bus.mem_addr, bus.mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_read_miss_hit();
    do_req(1'b0, 32'h10, 32'h0, lat, rd, rn, ra, wn, wa, wd, both);
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL miss_lat: got %0d want 4", lat);
    end
    checks++;
    if (rn !== 1 || ra !== 32'h10 || wn !== 0) begin
      errors++;
      $display("FAIL miss_mem: ren %0d @%h wen %0d want 1 @10 0", rn, ra, wn);
    end
    checks++;
    if (rd !== 32'hDEAD0010) begin
      errors++; $display("FAIL miss_rdata: got %h want dead0010", rd);
    end
    do_req(1'b0, 32'h10, 32'h0, lat, rd, rn, ra, wn, wa, wd, both);
    checks++;
    if (lat !== 1 || rn !== 0) begin
      errors++; $display("FAIL hit_lat: got %0d ren %0d want 1 0", lat, rn);
    end
    checks++;
    if (rd !== 32'hDEAD0010) begin
      errors++; $display("FAIL hit_rdata: got %h want dead0010", rd);
    end
  endtask

  task automatic test_write_hit();
    do_req(1'b1, 32'h10, 32'h12345678, lat, rd, rn, ra, wn, wa, wd, both);
    checks++;
    if (lat !== 1 || wn !== 0 || rn !== 0) begin
      errors++;
      $display("FAIL wr_hit: lat %0d wen %0d ren %0d want 1 0 0",
               lat, wn, rn);
    end
    checks++;
    if (bus.cpu_rdata !== 32'hDEAD0010) begin
      errors++;
      $display("FAIL rdata_hold: got %h want dead0010", bus.cpu_rdata);
    end
    do_req(1'b0, 32'h10, 32'h0, lat, rd, rn, ra, wn, wa, wd, both);
    checks++;
    if (lat !== 1 || rd !== 32'h12345678) begin
      errors++;
      $display("FAIL wr_readback: lat %0d got %h want 1 12345678", lat, rd);
    end
  endtask

  task automatic test_dirty_miss();
    do_req(1'b0, 32'h50, 32'h0, lat, rd, rn, ra, wn, wa, wd, both);
    checks++;
    if (wn !== 1 || wa !== 32'h10 || wd !== 32'h12345678) begin
      errors++;
      $display("FAIL wb_mem: wen %0d @%h d %h want 1 @10 12345678",
               wn, wa, wd);
    end
    checks++;
    if (rn !== 1 || ra !== 32'h50 || both !== 0) begin
      errors++;
      $display("FAIL wb_fill: ren %0d @%h both %0d want 1 @50 0",
               rn, ra, both);
    end
    checks++;
    if (lat !== 5 || rd !== 32'hDEAD0050) begin
      errors++;
      $display("FAIL dirty_miss: lat %0d got %h want 5 dead0050", lat, rd);
    end
    checks++;
    if (mem_peek(32'h10) !== 32'h12345678) begin
      errors++;
      $display("FAIL wb_commit: got %h want 12345678", mem_peek(32'h10));
    end
`ifdef CACHE_STATS_EN
    checks++;
    if (hit_count !== 32'd3 || miss_count !== 32'd2) begin
      errors++;
      $display("FAIL stats: hit %0d miss %0d want 3 2",
               hit_count, miss_count);
    end
`endif
  endtask

  task automatic test_cold_write();
    do_req(1'b1, 32'h20, 32'hA5A5A5A5, lat, rd, rn, ra, wn, wa, wd, both);
    checks++;
    if (rn !== 1 || ra !== 32'h20 || wn !== 0) begin
      errors++;
      $display("FAIL cold_wr_mem: ren %0d @%h wen %0d want 1 @20 0",
               rn, ra, wn);
    end
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL cold_wr_lat: got %0d want 4", lat);
    end
    checks++;
    if (mem_peek(32'h20) !== 32'hDEAD0020) begin
      errors++;
      $display("FAIL cold_wr_mem_kept: got %h want dead0020",
               mem_peek(32'h20));
    end
    do_req(1'b0, 32'h20, 32'h0, lat, rd, rn, ra, wn, wa, wd, both);
    checks++;
    if (lat !== 1 || rd !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL cold_wr_read: lat %0d got %h want 1 a5a5a5a5", lat, rd);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h30;
    @(posedge clk);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.cpu_ready !== 1'b1 || bus.cpu_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: ready %b done %b want 1 0",
               bus.cpu_ready, bus.cpu_done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.cpu_done) seen++;
    end
    checks++;
    if (seen !== 0 || bus.cpu_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_after: done %0d ready %b want 0 1",
               seen, bus.cpu_ready);
    end
    do_req(1'b0, 32'h30, 32'h0, lat, rd, rn, ra, wn, wa, wd, both);
    checks++;
    if (rn !== 1 || ra !== 32'h30 || lat !== 4 || rd !== 32'hDEAD0030) begin
      errors++;
      $display("FAIL mid_reset_remiss: ren %0d @%h lat %0d d %h",
               rn, ra, lat, rd);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    mem_q = '0;
    test_reset();
    test_read_miss_hit();
    test_write_hit();
    test_dirty_miss();
    test_cold_write();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
